// File: rtl/dm_pkg.sv
// Shared types for the debug module system bus access engine.
//   sberror_e   : sticky sberror codes reported to the debugger
//   sba_state_e : transfer state of dm_sba_ctrl
package dm_pkg;

  typedef enum logic [2:0] {
    SbErrNone    = 3'd0,
    SbErrTimeout = 3'd1,
    SbErrBus     = 3'd2,
    SbErrAlign   = 3'd3,
    SbErrSize    = 3'd4
  } sberror_e;

  typedef enum logic [1:0] {
    SbaIdle = 2'd0,
    SbaReq  = 2'd1,
    SbaResp = 2'd2
  } sba_state_e;

endpackage

// File: rtl/dm_sba_lanes.sv
// Byte-lane steering for system bus accesses. Purely combinational.
//   i_offset : byte offset of the access within the bus word
//   i_size   : log2 of access size in bytes
//   i_wdata  : right-justified write data from sbdata
//   i_rdata  : raw bus read data
//   o_be     : byte enables for the access
//   o_wdata  : write data shifted onto its byte lanes
//   o_rdata  : read data right-justified and zero-extended to the access size
module dm_sba_lanes #(
  parameter int BusWidth = 32,
  parameter int LaneBits = $clog2(BusWidth / 8)
) (
  input  logic [LaneBits-1:0]   i_offset,
  input  logic [2:0]            i_size,
  input  logic [BusWidth-1:0]   i_wdata,
  input  logic [BusWidth-1:0]   i_rdata,
  output logic [BusWidth/8-1:0] o_be,
  output logic [BusWidth-1:0]   o_wdata,
  output logic [BusWidth-1:0]   o_rdata
);

  localparam int Bytes = BusWidth / 8;

  logic [Bytes-1:0]    w_mask;
  logic [BusWidth-1:0] w_rshift;
  logic [LaneBits+2:0] w_shamt;

  always_comb begin
    w_mask = '0;
    for (int i = 0; i < Bytes; i++) begin
      w_mask[i] = (i < (1 << i_size));
    end
    w_shamt  = {i_offset, 3'b000};
    o_be     = w_mask << i_offset;
    o_wdata  = i_wdata << w_shamt;
    w_rshift = i_rdata >> w_shamt;
    o_rdata  = '0;
    for (int i = 0; i < Bytes; i++) begin
      if (w_mask[i]) o_rdata[8*i +: 8] = w_rshift[8*i +: 8];
    end
  end

endmodule

// File: rtl/dm_sba_ctrl.sv
// System bus access engine: turns sbaddress/sbdata events into single
// req/gnt/r_valid bus transactions, with lane steering, error detection,
// timeout and address auto-increment.
//   clk_i, rst_i, dmactive_i     : clock, sync reset, debug module active
//   master_*                     : system bus master port
//   sbaddress_*, sbdata_*, sb*_i : sbcs/sbaddress/sbdata events and fields
//   sbaddress_o/_valid_o         : incremented address write-back
//   sbdata_o/_valid_o            : read data write-back
//   sbbusy_o, sbbusyerror_o, sberror_o : status back to sbcs
//
// state   | meaning
// SbaIdle | no transfer; evaluates triggers and start checks
// SbaReq  | master_req_o high, waiting for grant
// SbaResp | granted, waiting for r_valid
module dm_sba_ctrl
  import dm_pkg::*;
#(
  parameter int BusWidth      = 32,
  parameter int AddrWidth     = 32,
  parameter int TimeoutCycles = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  dmactive_i,
  output logic                  master_req_o,
  output logic [AddrWidth-1:0]  master_add_o,
  output logic                  master_we_o,
  output logic [BusWidth-1:0]   master_wdata_o,
  output logic [BusWidth/8-1:0] master_be_o,
  input  logic                  master_gnt_i,
  input  logic                  master_r_valid_i,
  input  logic                  master_r_err_i,
  input  logic [BusWidth-1:0]   master_r_rdata_i,
  input  logic [AddrWidth-1:0]  sbaddress_i,
  input  logic                  sbaddress_write_valid_i,
  input  logic                  sbreadonaddr_i,
  input  logic                  sbautoincrement_i,
  input  logic [2:0]            sbaccess_i,
  input  logic                  sbreadondata_i,
  input  logic [BusWidth-1:0]   sbdata_i,
  input  logic                  sbdata_read_valid_i,
  input  logic                  sbdata_write_valid_i,
  input  logic [2:0]            sberror_clear_i,
  input  logic                  sbbusyerror_clear_i,
  output logic [AddrWidth-1:0]  sbaddress_o,
  output logic                  sbaddress_valid_o,
  output logic [BusWidth-1:0]   sbdata_o,
  output logic                  sbdata_valid_o,
  output logic                  sbbusy_o,
  output logic                  sbbusyerror_o,
  output logic [2:0]            sberror_o
);

  localparam int LaneBits = $clog2(BusWidth / 8);
  localparam int TcW      = (TimeoutCycles > 1) ? $clog2(TimeoutCycles + 1) : 1;

  sba_state_e            r_state;
  logic                  r_req;
  logic [AddrWidth-1:0]  r_addr;
  logic                  r_we;
  logic [2:0]            r_size;
  logic [BusWidth-1:0]   r_wdata;
  logic [BusWidth/8-1:0] r_be;
  logic [TcW-1:0]        r_tcnt;
  logic [AddrWidth-1:0]  r_sbaddress;
  logic                  r_sbaddress_valid;
  logic [BusWidth-1:0]   r_sbdata;
  logic                  r_sbdata_valid;
  logic                  r_busy;
  logic                  r_sbbusyerror;
  logic [2:0]            r_sberror;

  logic                  w_rd_evt;
  logic                  w_wr_evt;
  logic                  w_trigger;
  logic                  w_size_bad;
  logic [AddrWidth-1:0]  w_align_mask;
  logic                  w_misaligned;
  logic                  w_dbg_access;
  logic                  w_timeout;
  logic [LaneBits-1:0]   w_offset;
  logic [2:0]            w_size;
  logic [BusWidth/8-1:0] w_be;
  logic [BusWidth-1:0]   w_wdata;
  logic [BusWidth-1:0]   w_rdata;

  assign w_rd_evt     = (sbaddress_write_valid_i && sbreadonaddr_i) ||
                        (sbdata_read_valid_i && sbreadondata_i);
  assign w_wr_evt     = sbdata_write_valid_i;
  assign w_trigger    = (w_rd_evt || w_wr_evt) && (r_sberror == SbErrNone) && !r_sbbusyerror;
  assign w_size_bad   = sbaccess_i > 3'(LaneBits);
  assign w_align_mask = (AddrWidth'(1) << sbaccess_i) - AddrWidth'(1);
  assign w_misaligned = |(sbaddress_i & w_align_mask);
  assign w_dbg_access = sbaddress_write_valid_i || sbdata_write_valid_i || sbdata_read_valid_i;
  // ">=" so that a grant arriving on the terminal cycle still times out in Resp
  assign w_timeout    = (TimeoutCycles != 0) && (r_tcnt >= TcW'(TimeoutCycles - 1));

  // One steering instance: start-of-transfer lanes come from the live
  // sbaddress/sbaccess, response lanes from the latched transfer.
  assign w_offset = (r_state == SbaIdle) ? sbaddress_i[LaneBits-1:0] : r_addr[LaneBits-1:0];
  assign w_size   = (r_state == SbaIdle) ? sbaccess_i : r_size;

  dm_sba_lanes #(
    .BusWidth (BusWidth)
  ) u_lanes (
    .i_offset (w_offset),
    .i_size   (w_size),
    .i_wdata  (sbdata_i),
    .i_rdata  (master_r_rdata_i),
    .o_be     (w_be),
    .o_wdata  (w_wdata),
    .o_rdata  (w_rdata)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i || !dmactive_i) begin
      r_state           <= SbaIdle;
      r_req             <= 1'b0;
      r_addr            <= '0;
      r_we              <= 1'b0;
      r_size            <= '0;
      r_wdata           <= '0;
      r_be              <= '0;
      r_tcnt            <= '0;
      r_sbaddress       <= '0;
      r_sbaddress_valid <= 1'b0;
      r_sbdata          <= '0;
      r_sbdata_valid    <= 1'b0;
      r_busy            <= 1'b0;
      r_sbbusyerror     <= 1'b0;
      r_sberror         <= SbErrNone;
    end else begin
      r_sbdata_valid    <= 1'b0;
      r_sbaddress_valid <= 1'b0;
      // Clears first; any set below overrides them in the same cycle.
      r_sberror <= r_sberror & ~sberror_clear_i;
      if (sbbusyerror_clear_i) r_sbbusyerror <= 1'b0;
      if (r_busy && w_dbg_access) r_sbbusyerror <= 1'b1;

      case (r_state)
        SbaIdle: begin
          r_tcnt <= '0;
          if (w_trigger) begin
            if (w_size_bad) begin
              r_sberror <= SbErrSize;
            end else if (w_misaligned) begin
              r_sberror <= SbErrAlign;
            end else begin
              r_state <= SbaReq;
              r_busy  <= 1'b1;
              r_req   <= 1'b1;
              r_addr  <= sbaddress_i;
              r_size  <= sbaccess_i;
              r_we    <= w_wr_evt;
              r_be    <= w_be;
              r_wdata <= w_wdata;
            end
          end
        end
        SbaReq: begin
          if (master_gnt_i) begin
            r_state <= SbaResp;
            r_req   <= 1'b0;
            r_tcnt  <= r_tcnt + TcW'(1);
          end else if (w_timeout) begin
            r_sberror <= SbErrTimeout;
            r_req     <= 1'b0;
            r_state   <= SbaIdle;
            r_busy    <= 1'b0;
          end else begin
            r_tcnt <= r_tcnt + TcW'(1);
          end
        end
        SbaResp: begin
          if (master_r_valid_i) begin
            r_state <= SbaIdle;
            r_busy  <= 1'b0;
            if (master_r_err_i) begin
              r_sberror <= SbErrBus;
            end else begin
              if (!r_we) begin
                r_sbdata       <= w_rdata;
                r_sbdata_valid <= 1'b1;
              end
              if (sbautoincrement_i) begin
                r_sbaddress       <= r_addr + (AddrWidth'(1) << r_size);
                r_sbaddress_valid <= 1'b1;
              end
            end
          end else if (w_timeout) begin
            r_sberror <= SbErrTimeout;
            r_state   <= SbaIdle;
            r_busy    <= 1'b0;
          end else begin
            r_tcnt <= r_tcnt + TcW'(1);
          end
        end
        default: begin
          r_state <= SbaIdle;
          r_req   <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign master_req_o      = r_req;
  assign master_add_o      = r_addr;
  assign master_we_o       = r_we;
  assign master_wdata_o    = r_wdata;
  assign master_be_o       = r_be;
  assign sbaddress_o       = r_sbaddress;
  assign sbaddress_valid_o = r_sbaddress_valid;
  assign sbdata_o          = r_sbdata;
  assign sbdata_valid_o    = r_sbdata_valid;
  assign sbbusy_o          = r_busy;
  assign sbbusyerror_o     = r_sbbusyerror;
  assign sberror_o         = r_sberror;

endmodule

// File: tb/tb_dm_sba_ctrl.sv
// Directed bench for dm_sba_ctrl: a 32-bit instance (timeout 8) and a
// 64-bit instance, driven one after the other.
module tb_dm_sba_ctrl;

  logic clk = 1'b0;
  logic rst, dmactive;
  always #5 clk = ~clk;

  // 32-bit instance
  logic        req, we, gnt, rvalid, rerr;
  logic [31:0] add, wdata, rdata;
  logic [3:0]  be;
  logic [31:0] sbaddr, sbdata, sbaddr_o, sbdata_o;
  logic        sbaddr_wv, rdonaddr, autoinc, rdondata, sbdata_rv, sbdata_wv, busyerr_clr;
  logic [2:0]  sbaccess, err_clr, sberr;
  logic        sbaddr_v, sbdata_v, busy, busyerr;

  // 64-bit instance
  logic        req_b, we_b, gnt_b, rvalid_b, rerr_b;
  logic [31:0] add_b, sbaddr_b, sbaddr_o_b;
  logic [63:0] wdata_b, rdata_b, sbdata_b, sbdata_o_b;
  logic [7:0]  be_b;
  logic        sbaddr_wv_b, rdonaddr_b, autoinc_b, rdondata_b, sbdata_rv_b, sbdata_wv_b, busyerr_clr_b;
  logic [2:0]  sbaccess_b, err_clr_b, sberr_b;
  logic        sbaddr_v_b, sbdata_v_b, busy_b, busyerr_b;

  int errors = 0;
  int checks = 0;
  int n;

  dm_sba_ctrl #(.BusWidth(32), .AddrWidth(32), .TimeoutCycles(8)) u32 (
    .clk_i(clk), .rst_i(rst), .dmactive_i(dmactive),
    .master_req_o(req), .master_add_o(add), .master_we_o(we),
    .master_wdata_o(wdata), .master_be_o(be), .master_gnt_i(gnt),
    .master_r_valid_i(rvalid), .master_r_err_i(rerr), .master_r_rdata_i(rdata),
    .sbaddress_i(sbaddr), .sbaddress_write_valid_i(sbaddr_wv), .sbreadonaddr_i(rdonaddr),
    .sbautoincrement_i(autoinc), .sbaccess_i(sbaccess), .sbreadondata_i(rdondata),
    .sbdata_i(sbdata), .sbdata_read_valid_i(sbdata_rv), .sbdata_write_valid_i(sbdata_wv),
    .sberror_clear_i(err_clr), .sbbusyerror_clear_i(busyerr_clr),
    .sbaddress_o(sbaddr_o), .sbaddress_valid_o(sbaddr_v), .sbdata_o(sbdata_o),
    .sbdata_valid_o(sbdata_v), .sbbusy_o(busy), .sbbusyerror_o(busyerr), .sberror_o(sberr)
  );

  dm_sba_ctrl #(.BusWidth(64), .AddrWidth(32), .TimeoutCycles(8)) u64 (
    .clk_i(clk), .rst_i(rst), .dmactive_i(dmactive),
    .master_req_o(req_b), .master_add_o(add_b), .master_we_o(we_b),
    .master_wdata_o(wdata_b), .master_be_o(be_b), .master_gnt_i(gnt_b),
    .master_r_valid_i(rvalid_b), .master_r_err_i(rerr_b), .master_r_rdata_i(rdata_b),
    .sbaddress_i(sbaddr_b), .sbaddress_write_valid_i(sbaddr_wv_b), .sbreadonaddr_i(rdonaddr_b),
    .sbautoincrement_i(autoinc_b), .sbaccess_i(sbaccess_b), .sbreadondata_i(rdondata_b),
    .sbdata_i(sbdata_b), .sbdata_read_valid_i(sbdata_rv_b), .sbdata_write_valid_i(sbdata_wv_b),
    .sberror_clear_i(err_clr_b), .sbbusyerror_clear_i(busyerr_clr_b),
    .sbaddress_o(sbaddr_o_b), .sbaddress_valid_o(sbaddr_v_b), .sbdata_o(sbdata_o_b),
    .sbdata_valid_o(sbdata_v_b), .sbbusy_o(busy_b), .sbbusyerror_o(busyerr_b), .sberror_o(sberr_b)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; dmactive = 1'b1;
    gnt = 0; rvalid = 0; rerr = 0; rdata = '0;
    sbaddr = '0; sbaddr_wv = 0; rdonaddr = 0; autoinc = 0; sbaccess = '0; rdondata = 0;
    sbdata = '0; sbdata_rv = 0; sbdata_wv = 0; err_clr = '0; busyerr_clr = 0;
    gnt_b = 0; rvalid_b = 0; rerr_b = 0; rdata_b = '0;
    sbaddr_b = '0; sbaddr_wv_b = 0; rdonaddr_b = 0; autoinc_b = 0; sbaccess_b = '0; rdondata_b = 0;
    sbdata_b = '0; sbdata_rv_b = 0; sbdata_wv_b = 0; err_clr_b = '0; busyerr_clr_b = 0;
    cyc(); cyc();
    chk("rst_req", req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sberror", sberr, 0);
    chk("rst_busyerr", busyerr, 0);
    chk("rst_sbdata", sbdata_o, 0);
    rst = 1'b0;
    cyc();

    // byte write at 0x1003
    sbaddr = 32'h1003; sbaccess = 3'd0; sbdata = 32'hA5; sbdata_wv = 1;
    cyc();
    sbdata_wv = 0;
    chk("bw_req", req, 1);
    chk("bw_add", add, 32'h1003);
    chk("bw_be", be, 4'b1000);
    chk("bw_wdata", wdata, 32'hA500_0000);
    chk("bw_we", we, 1);
    chk("bw_busy", busy, 1);
    gnt = 1; cyc(); gnt = 0;
    chk("bw_req_drop", req, 0);
    chk("bw_busy_resp", busy, 1);
    rvalid = 1; cyc(); rvalid = 0;
    chk("bw_done_busy", busy, 0);
    chk("bw_done_err", sberr, 0);
    chk("bw_no_data", sbdata_v, 0);

    // misaligned word read
    sbaddr = 32'h1002; sbaccess = 3'd2; rdonaddr = 1; sbaddr_wv = 1;
    cyc(); sbaddr_wv = 0;
    chk("mis_req", req, 0);
    chk("mis_err", sberr, 3);
    err_clr = 3'b111; cyc(); err_clr = '0;
    chk("mis_clr", sberr, 0);

    // oversized access
    sbaddr = 32'h1000; sbaccess = 3'd3; sbaddr_wv = 1;
    cyc(); sbaddr_wv = 0;
    chk("size_req", req, 0);
    chk("size_err", sberr, 4);
    // blocked while error is set
    sbaccess = 3'd2; sbaddr_wv = 1;
    cyc(); sbaddr_wv = 0;
    chk("blk_req", req, 0);
    chk("blk_err", sberr, 4);
    err_clr = 3'b111; cyc(); err_clr = '0;
    chk("size_clr", sberr, 0);
    // set and clear together: set wins
    sbaddr = 32'h1002; sbaccess = 3'd2; sbaddr_wv = 1; err_clr = 3'b111;
    cyc(); sbaddr_wv = 0; err_clr = '0;
    chk("setwins_err", sberr, 3);
    err_clr = 3'b111; cyc(); err_clr = '0;
    chk("setwins_clr", sberr, 0);

    // word read via sbdata read, autoincrement, zero-cycle grant
    sbaddr = 32'h1000; sbaccess = 3'd2; autoinc = 1; rdondata = 1; sbdata_rv = 1;
    cyc(); sbdata_rv = 0; gnt = 1;
    chk("rw_req", req, 1);
    chk("rw_we", we, 0);
    chk("rw_be", be, 4'b1111);
    chk("rw_add", add, 32'h1000);
    cyc(); gnt = 0;
    chk("rw_req_drop", req, 0);
    rdata = 32'hDEAD_BEEF; rvalid = 1; cyc(); rvalid = 0;
    chk("rw_busy", busy, 0);
    chk("rw_dv", sbdata_v, 1);
    chk("rw_data", sbdata_o, 32'hDEAD_BEEF);
    chk("rw_av", sbaddr_v, 1);
    chk("rw_addr", sbaddr_o, 32'h1004);
    cyc();
    chk("rw_dv_once", sbdata_v, 0);
    chk("rw_av_once", sbaddr_v, 0);

    // halfword read at lane 2
    sbaddr = 32'h1002; sbaccess = 3'd1; rdonaddr = 1; sbaddr_wv = 1; autoinc = 0;
    cyc(); sbaddr_wv = 0;
    chk("hw_be", be, 4'b1100);
    gnt = 1; cyc(); gnt = 0;
    rdata = 32'hCAFE_1234; rvalid = 1; cyc(); rvalid = 0;
    chk("hw_data", sbdata_o, 32'h0000_CAFE);
    chk("hw_av", sbaddr_v, 0);

    // bus error on a read
    sbaddr = 32'h1000; sbaccess = 3'd2; autoinc = 1; sbaddr_wv = 1;
    cyc(); sbaddr_wv = 0;
    gnt = 1; cyc(); gnt = 0;
    rdata = 32'h5555_5555; rvalid = 1; rerr = 1; cyc(); rvalid = 0; rerr = 0;
    chk("be_err", sberr, 2);
    chk("be_dv", sbdata_v, 0);
    chk("be_av", sbaddr_v, 0);
    chk("be_busy", busy, 0);
    err_clr = 3'b010; cyc(); err_clr = '0;
    chk("be_clr", sberr, 0);

    // timeout with grant low
    autoinc = 0; sbaddr_wv = 1;
    cyc(); sbaddr_wv = 0;
    n = 0;
    while (req && n < 20) begin
      n++;
      cyc();
    end
    chk("to_req_cycles", n, 8);
    chk("to_err", sberr, 1);
    chk("to_busy", busy, 0);
    rdata = 32'h7777_7777; rvalid = 1; cyc(); rvalid = 0;
    chk("to_late_dv", sbdata_v, 0);
    chk("to_late_err", sberr, 1);
    err_clr = 3'b001; cyc(); err_clr = '0;
    chk("to_clr", sberr, 0);

    // busy error during Resp
    sbaddr = 32'h1000; sbaccess = 3'd2; sbdata = 32'h1122_3344; rdonaddr = 0; sbdata_wv = 1;
    cyc(); sbdata_wv = 0;
    chk("bz_wdata", wdata, 32'h1122_3344);
    gnt = 1; cyc(); gnt = 0;
    sbdata_wv = 1; cyc(); sbdata_wv = 0;
    chk("bz_set", busyerr, 1);
    chk("bz_busy", busy, 1);
    rvalid = 1; cyc(); rvalid = 0;
    chk("bz_done", busy, 0);
    chk("bz_done_err", sberr, 0);
    chk("bz_sticky", busyerr, 1);
    sbdata_wv = 1; cyc(); sbdata_wv = 0;
    chk("bz_blocked", req, 0);
    busyerr_clr = 1; cyc(); busyerr_clr = 0;
    chk("bz_clr", busyerr, 0);

    // reset in Req
    sbdata_wv = 1; cyc(); sbdata_wv = 0;
    chk("rr_req", req, 1);
    sbaddr_wv = 1; cyc(); sbaddr_wv = 0;
    chk("rr_busyerr", busyerr, 1);
    rst = 1; cyc(); rst = 0;
    chk("rr_req0", req, 0);
    chk("rr_busy0", busy, 0);
    chk("rr_busyerr0", busyerr, 0);
    chk("rr_err0", sberr, 0);

    // dmactive low in Req
    sbdata_wv = 1; cyc(); sbdata_wv = 0;
    chk("da_req", req, 1);
    sbaddr_wv = 1; cyc(); sbaddr_wv = 0;
    chk("da_busyerr", busyerr, 1);
    dmactive = 0; cyc(); dmactive = 1;
    chk("da_req0", req, 0);
    chk("da_busy0", busy, 0);
    chk("da_busyerr0", busyerr, 0);

    // 64-bit halfword read with autoincrement at 0x2006
    sbaddr_b = 32'h2006; sbaccess_b = 3'd1; autoinc_b = 1; rdonaddr_b = 1; sbaddr_wv_b = 1;
    cyc(); sbaddr_wv_b = 0;
    chk("w64_req", req_b, 1);
    chk("w64_add", add_b, 32'h2006);
    chk("w64_be", be_b, 8'b1100_0000);
    gnt_b = 1; cyc(); gnt_b = 0;
    rdata_b = 64'h1234_5678_9ABC_DEF0; rvalid_b = 1; cyc(); rvalid_b = 0;
    chk("w64_data", sbdata_o_b, 64'h1234);
    chk("w64_dv", sbdata_v_b, 1);
    chk("w64_addr", sbaddr_o_b, 32'h2008);
    chk("w64_av", sbaddr_v_b, 1);
    cyc();
    chk("w64_dv_once", sbdata_v_b, 0);

    // 64-bit word write at upper lane
    sbaddr_b = 32'h2004; sbaccess_b = 3'd2; sbdata_b = 64'hAABB_CCDD; sbdata_wv_b = 1;
    cyc(); sbdata_wv_b = 0;
    chk("w64w_be", be_b, 8'hF0);
    chk("w64w_wdata", wdata_b, 64'hAABB_CCDD_0000_0000);
    chk("w64w_we", we_b, 1);
    gnt_b = 1; cyc(); gnt_b = 0;
    rvalid_b = 1; cyc(); rvalid_b = 0;
    chk("w64w_busy", busy_b, 0);
    chk("w64w_addr", sbaddr_o_b, 32'h2008);
    chk("w64w_err", sberr_b, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
